// File: rtl/lsb_mem_port.sv
// ============================================================================
// lsb_mem_port
// ----------------------------------------------------------------------------
// Byte-serialising memory port for the load/store buffer. It accepts one
// byte, halfword or word access at a time and drives the byte-wide RAM one
// byte per cycle. Loads are gathered little-endian and sign- or zero-extended.
// Stores send one byte per cycle, starting with the lowest byte.
//
// Optional feature (macro IO_FULL_STALL_EN):
//   When the macro is defined, a store byte that targets the I/O region
//   (lsb_addr[17:16] == IO_BASE_HI) while io_buffer_full is high is held
//   back: lsb_valid/lsb_wr drop for that cycle and the byte is retried.
//   When the macro is not defined, io_buffer_full is ignored.
//
// Parameters:
//   IO_BASE_HI     value of addr[17:16] that selects the memory-mapped I/O region
//
// Ports:
//   clk_in         clock
//   rst_in         synchronous, active-high reset
//   req_valid      request present
//   req_ready      port idle and will accept a request this cycle
//   req_addr       byte address of the access
//   req_wr         1 = store, 0 = load
//   req_size       00 byte, 01 half, 10/11 word
//   req_signed     sign-extend the load result
//   req_wdata      store data (low bytes used)
//   flush          misprediction flush; aborts loads, ignored by stores
//   resp_valid     one-cycle completion pulse
//   resp_rdata     load result (0 for stores), held until the next response
//   lsb_valid      bus request to the memory controller
//   lsb_addr       byte address on the bus
//   lsb_wr         write strobe
//   lsb_data       write byte
//   lsb_read_data  RAM read byte, valid one cycle after its address
//   io_buffer_full UART output buffer full
// ============================================================================
module lsb_mem_port #(
   parameter logic [1:0] IO_BASE_HI = 2'b11
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_wr,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_wdata,
   input  logic        flush,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        lsb_valid,
   output logic [31:0] lsb_addr,
   output logic        lsb_wr,
   output logic [7:0]  lsb_data,
   input  logic [7:0]  lsb_read_data,
   input  logic        io_buffer_full
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_LWAIT = 2'd2,
      S_STORE = 2'd3
   } state_t;

   state_t      r_state,      w_state_nxt;
   logic [1:0]  r_idx,        w_idx_nxt;      // index of the byte currently on the bus
   logic [1:0]  r_last,       w_last_nxt;     // index of the final byte of the access
   logic [1:0]  r_size,       w_size_nxt;
   logic        r_signed,     w_signed_nxt;
   logic [31:0] r_wdata,      w_wdata_nxt;
   logic [23:0] r_rbuf,       w_rbuf_nxt;     // bytes 0..2 of a load; byte 3 arrives in LWAIT
   logic        r_lsb_valid,  w_lsb_valid_nxt;
   logic        r_lsb_wr,     w_lsb_wr_nxt;
   logic [31:0] r_lsb_addr,   w_lsb_addr_nxt;
   logic [7:0]  r_lsb_data,   w_lsb_data_nxt;
   logic        r_resp_valid, w_resp_valid_nxt;
   logic [31:0] r_resp_rdata, w_resp_rdata_nxt;

   logic        w_handshake;
   logic        w_stall;
   logic [31:0] w_load_result;

   // Select byte idx of a 32-bit word
   function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      return b;
   endfunction

   // Index of the last byte for a given access size
   function automatic logic [1:0] last_index(input logic [1:0] size);
      logic [1:0] l;
      case (size)
         2'b00:   l = 2'd0;
         2'b01:   l = 2'd1;
         default: l = 2'd3;
      endcase
      return l;
   endfunction

   assign req_ready   = (r_state == S_IDLE) && !rst_in && !flush;
   assign w_handshake = req_valid && req_ready;

`ifdef IO_FULL_STALL_EN
   assign w_stall = (r_state == S_STORE) && (r_lsb_addr[17:16] == IO_BASE_HI) && io_buffer_full;
`else
   logic [2:0] w_unused_io;
   assign w_unused_io = {io_buffer_full, IO_BASE_HI};
   assign w_stall     = 1'b0;
`endif

   // A stalled store byte is withdrawn from the bus for that cycle only
   assign lsb_valid  = r_lsb_valid & ~w_stall;
   assign lsb_wr     = r_lsb_wr & ~w_stall;
   assign lsb_addr   = r_lsb_addr;
   assign lsb_data   = r_lsb_data;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;

   // Assemble the final load value from the buffered bytes and the byte arriving now
   always_comb begin
      w_load_result = 32'd0;
      case (r_size)
         2'b00:   w_load_result = {{24{r_signed & lsb_read_data[7]}}, lsb_read_data};
         2'b01:   w_load_result = {{16{r_signed & lsb_read_data[7]}}, lsb_read_data, r_rbuf[7:0]};
         default: w_load_result = {lsb_read_data, r_rbuf};
      endcase
   end

   // Next-state and next-output logic for the access sequencer
   always_comb begin
      w_state_nxt      = r_state;
      w_idx_nxt        = r_idx;
      w_last_nxt       = r_last;
      w_size_nxt       = r_size;
      w_signed_nxt     = r_signed;
      w_wdata_nxt      = r_wdata;
      w_rbuf_nxt       = r_rbuf;
      w_lsb_valid_nxt  = r_lsb_valid;
      w_lsb_wr_nxt     = r_lsb_wr;
      w_lsb_addr_nxt   = r_lsb_addr;
      w_lsb_data_nxt   = r_lsb_data;
      w_resp_valid_nxt = 1'b0;
      w_resp_rdata_nxt = r_resp_rdata;

      case (r_state)
         S_IDLE: begin
            w_lsb_valid_nxt = 1'b0;
            w_lsb_wr_nxt    = 1'b0;
            if (w_handshake) begin
               w_state_nxt     = req_wr ? S_STORE : S_LOAD;
               w_idx_nxt       = 2'd0;
               w_last_nxt      = last_index(req_size);
               w_size_nxt      = req_size;
               w_signed_nxt    = req_signed;
               w_wdata_nxt     = req_wdata;
               w_rbuf_nxt      = 24'd0;
               w_lsb_valid_nxt = 1'b1;
               w_lsb_wr_nxt    = req_wr;
               w_lsb_addr_nxt  = req_addr;
               // lsb_data only changes for stores; loads leave the last write byte on it
               if (req_wr) begin
                  w_lsb_data_nxt = req_wdata[7:0];
               end else begin
                  w_lsb_data_nxt = r_lsb_data;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end

         S_LOAD: begin
            if (flush) begin
               w_state_nxt     = S_IDLE;
               w_lsb_valid_nxt = 1'b0;
               w_lsb_wr_nxt    = 1'b0;
            end else begin
               // The byte returning now belongs to the address issued last cycle
               case (r_idx)
                  2'd1:    w_rbuf_nxt[7:0]   = lsb_read_data;
                  2'd2:    w_rbuf_nxt[15:8]  = lsb_read_data;
                  2'd3:    w_rbuf_nxt[23:16] = lsb_read_data;
                  default: w_rbuf_nxt        = r_rbuf;
               endcase
               if (r_idx == r_last) begin
                  w_state_nxt     = S_LWAIT;
                  w_lsb_valid_nxt = 1'b0;
               end else begin
                  w_idx_nxt      = r_idx + 2'd1;
                  w_lsb_addr_nxt = r_lsb_addr + 32'd1;
               end
            end
         end

         S_LWAIT: begin
            w_state_nxt = S_IDLE;
            if (flush) begin
               w_lsb_valid_nxt = 1'b0;
            end else begin
               w_resp_valid_nxt = 1'b1;
               w_resp_rdata_nxt = w_load_result;
            end
         end

         S_STORE: begin
            if (w_stall) begin
               w_state_nxt = S_STORE;
            end else if (r_idx == r_last) begin
               w_state_nxt      = S_IDLE;
               w_lsb_valid_nxt  = 1'b0;
               w_lsb_wr_nxt     = 1'b0;
               w_resp_valid_nxt = 1'b1;
               w_resp_rdata_nxt = 32'd0;
            end else begin
               w_idx_nxt      = r_idx + 2'd1;
               w_lsb_addr_nxt = r_lsb_addr + 32'd1;
               w_lsb_data_nxt = pick_byte(r_wdata, r_idx + 2'd1);
            end
         end

         default: begin
            w_state_nxt     = S_IDLE;
            w_lsb_valid_nxt = 1'b0;
            w_lsb_wr_nxt    = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state      <= S_IDLE;
         r_idx        <= 2'd0;
         r_last       <= 2'd0;
         r_size       <= 2'd0;
         r_signed     <= 1'b0;
         r_wdata      <= 32'd0;
         r_rbuf       <= 24'd0;
         r_lsb_valid  <= 1'b0;
         r_lsb_wr     <= 1'b0;
         r_lsb_addr   <= 32'd0;
         r_lsb_data   <= 8'd0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_idx        <= w_idx_nxt;
         r_last       <= w_last_nxt;
         r_size       <= w_size_nxt;
         r_signed     <= w_signed_nxt;
         r_wdata      <= w_wdata_nxt;
         r_rbuf       <= w_rbuf_nxt;
         r_lsb_valid  <= w_lsb_valid_nxt;
         r_lsb_wr     <= w_lsb_wr_nxt;
         r_lsb_addr   <= w_lsb_addr_nxt;
         r_lsb_data   <= w_lsb_data_nxt;
         r_resp_valid <= w_resp_valid_nxt;
         r_resp_rdata <= w_resp_rdata_nxt;
      end
   end

endmodule

// File: tb/tb_lsb_mem_port.sv
// Testbench for lsb_mem_port: byte-wide RAM model, response scoreboard,
// a vector table of accesses and hand-written multi-cycle sequences.
module tb_lsb_mem_port;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_wr;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_wdata;
   logic        flush;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        lsb_valid;
   logic [31:0] lsb_addr;
   logic        lsb_wr;
   logic [7:0]  lsb_data;
   logic [7:0]  lsb_read_data;
   logic        io_buffer_full;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] sb_q[$];

   logic [7:0] mem [0:4095];
   logic [7:0] rd_q;

   typedef struct packed {
      logic [31:0] addr;
      logic        wr;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [0:13];

   always #5 clk_in = ~clk_in;

   lsb_mem_port #(.IO_BASE_HI(2'b11)) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wr(req_wr), .req_size(req_size), .req_signed(req_signed),
      .req_wdata(req_wdata), .flush(flush),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .lsb_valid(lsb_valid), .lsb_addr(lsb_addr), .lsb_wr(lsb_wr),
      .lsb_data(lsb_data), .lsb_read_data(lsb_read_data),
      .io_buffer_full(io_buffer_full)
   );

   // RAM model: write on strobe, read data one cycle after the address
   always @(posedge clk_in) begin
      if (lsb_valid === 1'b1 && lsb_wr === 1'b1) mem[lsb_addr[11:0]] <= lsb_data;
      rd_q <= mem[lsb_addr[11:0]];
   end
   assign lsb_read_data = rd_q;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard: every response is matched against the oldest expectation
   always @(negedge clk_in) begin
      if (resp_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_unexpected: resp_valid with rdata %h, expected no response at %0t",
                     resp_rdata, $time);
         end else begin
            chk("sb_rdata", resp_rdata, sb_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #2;
   endtask

   // Present a request, wait for the handshake, return in cycle c1 with inputs scrambled
   task automatic issue(input logic [31:0] a, input logic w, input logic [1:0] sz,
                        input logic sg, input logic [31:0] wd, input logic [31:0] exp,
                        input logic push);
      int g = 0;
      req_valid = 1'b1; req_addr = a; req_wr = w; req_size = sz;
      req_signed = sg; req_wdata = wd;
      #1;
      while (req_ready !== 1'b1 && g < 20) begin
         tick(); #1; g++;
      end
      chk("handshake_ready", {31'd0, req_ready}, 32'd1);
      if (req_ready === 1'b1 && push) sb_q.push_back(exp);
      tick();
      req_valid = 1'b0; req_addr = 32'hDEAD_BEEF; req_wdata = $urandom;
      req_size = 2'($urandom_range(0, 3)); req_wr = ~w; req_signed = ~sg;
   endtask

   task automatic wait_resp(input int start, input int exp_lat, input string nm);
      int cyc = start;
      while (resp_valid !== 1'b1 && cyc < start + 30) begin
         tick(); cyc++;
      end
      chk(nm, cyc, exp_lat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      int  lat;
      logic seen;
      logic [31:0] a;

      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      mem[12'h100] = 8'h11; mem[12'h101] = 8'h22; mem[12'h102] = 8'h33; mem[12'h103] = 8'h44;
      mem[12'h080] = 8'h80;
      mem[12'h200] = 8'h01; mem[12'h201] = 8'h80;
      mem[12'h300] = 8'h7F;
      mem[12'h302] = 8'h34; mem[12'h303] = 8'hF2;
      mem[12'hFFE] = 8'hA1; mem[12'hFFF] = 8'hB2; mem[12'h000] = 8'hC3; mem[12'h001] = 8'hD4;

      //            addr          wr    size   sgn   wdata          expected
      vecs[0]  = {32'h0000_0100, 1'b0, 2'b10, 1'b0, 32'h0,         32'h4433_2211};
      vecs[1]  = {32'h0000_0080, 1'b0, 2'b00, 1'b1, 32'h0,         32'hFFFF_FF80};
      vecs[2]  = {32'h0000_0080, 1'b0, 2'b00, 1'b0, 32'h0,         32'h0000_0080};
      vecs[3]  = {32'h0000_0200, 1'b0, 2'b01, 1'b0, 32'h0,         32'h0000_8001};
      vecs[4]  = {32'h0000_0200, 1'b0, 2'b01, 1'b1, 32'h0,         32'hFFFF_8001};
      vecs[5]  = {32'h0000_0300, 1'b0, 2'b00, 1'b1, 32'h0,         32'h0000_007F};
      vecs[6]  = {32'h0000_0302, 1'b0, 2'b01, 1'b1, 32'h0,         32'hFFFF_F234};
      vecs[7]  = {32'h0000_0100, 1'b0, 2'b11, 1'b1, 32'h0,         32'h4433_2211};
      vecs[8]  = {32'h0000_0101, 1'b0, 2'b10, 1'b0, 32'h0,         32'h0044_3322};
      vecs[9]  = {32'h0000_0400, 1'b1, 2'b10, 1'b0, 32'hCAFE_F00D, 32'h0};
      vecs[10] = {32'h0000_0400, 1'b0, 2'b10, 1'b0, 32'h0,         32'hCAFE_F00D};
      vecs[11] = {32'h0000_0500, 1'b1, 2'b00, 1'b0, 32'h1234_56AB, 32'h0};
      vecs[12] = {32'h0000_0502, 1'b1, 2'b01, 1'b0, 32'hFFFF_9A77, 32'h0};
      vecs[13] = {32'h0000_0500, 1'b0, 2'b10, 1'b0, 32'h0,         32'h9A77_00AB};

      rst_in = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_wr = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_wdata = 32'h0; flush = 1'b0; io_buffer_full = 1'b0;

      // Reset state
      repeat (3) tick();
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_lsb_valid",  {31'd0, lsb_valid},  32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_ready_low",  {31'd0, req_ready},  32'd0);
      rst_in = 1'b0;
      #1;
      chk("rst_ready_after", {31'd0, req_ready}, 32'd1);

      // Vector table: accesses issued back-to-back in the response cycle
      for (int i = 0; i < 14; i++) begin
         lat = (vecs[i].size == 2'b00) ? 1 : (vecs[i].size == 2'b01) ? 2 : 4;
         lat = lat + (vecs[i].wr ? 1 : 2);
         issue(vecs[i].addr, vecs[i].wr, vecs[i].size, vecs[i].sgn, vecs[i].wdata,
               vecs[i].exp, 1'b1);
         chk("resp_pulse_end", {31'd0, resp_valid}, 32'd0);
         wait_resp(1, lat, "tbl_latency");
         chk("tbl_ready_in_resp", {31'd0, req_ready}, 32'd1);
      end

      // Word load address sequence
      issue(32'h100, 1'b0, 2'b10, 1'b0, 32'h0, 32'h4433_2211, 1'b1);
      for (int i = 0; i < 4; i++) begin
         chk("lw_valid", {31'd0, lsb_valid}, 32'd1);
         chk("lw_wr",    {31'd0, lsb_wr},    32'd0);
         chk("lw_addr",  lsb_addr, 32'h100 + 32'(i));
         tick();
      end
      chk("lw_idle_c5", {31'd0, lsb_valid}, 32'd0);
      wait_resp(5, 6, "lw_latency");

      // Halfword store, then back-to-back readback in the response cycle
      issue(32'h20, 1'b1, 2'b01, 1'b0, 32'hFFFF_BEEF, 32'h0, 1'b1);
      chk("sh_c1_wr",   {31'd0, lsb_wr}, 32'd1);
      chk("sh_c1_addr", lsb_addr, 32'h20);
      chk("sh_c1_data", {24'd0, lsb_data}, 32'hEF);
      tick();
      chk("sh_c2_addr", lsb_addr, 32'h21);
      chk("sh_c2_data", {24'd0, lsb_data}, 32'hBE);
      tick();
      chk("sh_c3_resp",  {31'd0, resp_valid}, 32'd1);
      chk("sh_c3_ready", {31'd0, req_ready},  32'd1);
      issue(32'h20, 1'b0, 2'b01, 1'b0, 32'h0, 32'h0000_BEEF, 1'b1);
      wait_resp(1, 4, "lh_b2b_latency");

      // Load flushed in c2: no response
      issue(32'h100, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      chk("flush_ld_valid", {31'd0, lsb_valid}, 32'd0);
      chk("flush_ld_ready", {31'd0, req_ready}, 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (resp_valid === 1'b1) seen = 1'b1;
         tick();
      end
      chk("flush_ld_no_resp", {31'd0, seen}, 32'd0);

      // Same flush during a store has no effect
      issue(32'h600, 1'b1, 2'b10, 1'b0, 32'h0102_0304, 32'h0, 1'b1);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_st_valid", {31'd0, lsb_valid}, 32'd1);
      chk("flush_st_wr",    {31'd0, lsb_wr},    32'd1);
      chk("flush_st_addr",  lsb_addr, 32'h602);
      chk("flush_st_data",  {24'd0, lsb_data}, 32'h02);
      wait_resp(3, 5, "flush_st_latency");

      // Address wraparound
      issue(32'hFFFF_FFFE, 1'b0, 2'b10, 1'b0, 32'h0, 32'hD4C3_B2A1, 1'b1);
      a = 32'hFFFF_FFFE;
      for (int i = 0; i < 4; i++) begin
         chk("wrap_addr", lsb_addr, a);
         a = a + 32'd1;
         tick();
      end
      wait_resp(5, 6, "wrap_latency");

      // Reset in c2 of a load
      issue(32'h100, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      rst_in = 1'b1;
      tick();
      chk("mid_rst_lsb_valid",  {31'd0, lsb_valid},  32'd0);
      chk("mid_rst_lsb_wr",     {31'd0, lsb_wr},     32'd0);
      chk("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("mid_rst_resp_rdata", resp_rdata, 32'd0);
      chk("mid_rst_lsb_addr",   lsb_addr, 32'd0);
      chk("mid_rst_lsb_data",   {24'd0, lsb_data}, 32'd0);
      rst_in = 1'b0;
      #1;
      chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
      repeat (6) tick();

      // Store into the I/O region while the UART buffer is full
      io_buffer_full = 1'b1;
      issue(32'h0003_0000, 1'b1, 2'b00, 1'b0, 32'h0000_005A, 32'h0, 1'b1);
`ifdef IO_FULL_STALL_EN
      for (int i = 0; i < 3; i++) begin
         chk("io_stall_valid", {31'd0, lsb_valid}, 32'd0);
         chk("io_stall_wr",    {31'd0, lsb_wr},    32'd0);
         tick();
      end
      io_buffer_full = 1'b0;
      #1;
      chk("io_c4_valid", {31'd0, lsb_valid}, 32'd1);
      chk("io_c4_addr",  lsb_addr, 32'h0003_0000);
      chk("io_c4_data",  {24'd0, lsb_data}, 32'h5A);
      wait_resp(4, 5, "io_stall_latency");
`else
      chk("io_nostall_valid", {31'd0, lsb_valid}, 32'd1);
      chk("io_nostall_wr",    {31'd0, lsb_wr},    32'd1);
      chk("io_nostall_data",  {24'd0, lsb_data}, 32'h5A);
      wait_resp(1, 2, "io_nostall_latency");
`endif
      io_buffer_full = 1'b0;

      repeat (5) tick();
      chk("sb_drain", sb_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
